// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning blocks: FSM state
// encoding, default timing derived from the system clock, and sizing helpers.
package btn_pkg;

   // System clock frequency that every button block is timed against.
   localparam int CLK_HZ = 50_000_000;

   // Default timing: 1 ms debounce, 0.5 s before the first repeat, then 10 Hz.
   localparam int DB_CYCLES_DEF     = CLK_HZ / 1000;
   localparam int REPEAT_DELAY_DEF  = CLK_HZ / 2;
   localparam int REPEAT_PERIOD_DEF = CLK_HZ / 10;

   // Debounce / repeat FSM states, 3-bit encoding.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ARMING    = 3'd1,
      HELD      = 3'd2,
      REPEATING = 3'd3,
      RELEASING = 3'd4
   } state_t;

   // Largest of three cycle counts.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

   // Timer width able to hold (largest count - 1); never narrower than 1 bit.
   function automatic int timer_width(input int a, input int b, input int c);
      int m;
      m = max3(a, b, c);
      if (m <= 1) return 1;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/btn_step_pulse_if.sv
// Button-side bundle: raw pad input in, step strobe and debounced level out.
interface btn_step_pulse_if;
   logic btn_in;
   logic pulse;
   logic btn_db;

   // Stimulus / pad side: drives the raw button, observes the results.
   modport master (
      output btn_in,
      input  pulse,
      input  btn_db
   );

   // Conditioning block side.
   modport slave (
      input  btn_in,
      output pulse,
      output btn_db
   );
endinterface

// File: rtl/btn_step_pulse_sync_2ff.sv
// Two-flop synchroniser for one asynchronous bit into the clkf domain.
module sync_2ff (
   input  logic clkf,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_reg;
   logic sync_reg;

   // Shift the pad value through two flops; both clear on reset so a held
   // button looks like a fresh press once reset is released.
   always_ff @(posedge clkf) begin
      if (rst) begin
         meta_reg <= 1'b0;
         sync_reg <= 1'b0;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/btn_step_pulse.sv
// Push-button conditioner: synchronises the pad, debounces press and release,
// and emits one-cycle step strobes (optionally auto-repeating while held).
module btn_step_pulse
   import btn_pkg::*;
#(
   parameter int DB_CYCLES     = DB_CYCLES_DEF,
   parameter int REPEAT_EN     = 1,
   parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
   input  logic                clkf,
   input  logic                rst,
   btn_step_pulse_if.slave     bus
);

   localparam int TW = timer_width(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

   // Terminal counts: the timer starts at 0 on entry, so N cycles end at N-1.
   localparam logic [TW-1:0] DB_LAST  = TW'(DB_CYCLES - 1);
   localparam logic [TW-1:0] RD_LAST  = TW'(REPEAT_DELAY - 1);
   localparam logic [TW-1:0] RP_LAST  = TW'(REPEAT_PERIOD - 1);
   localparam logic [TW-1:0] TMR_MAX  = '1;
   localparam logic [TW-1:0] TMR_ONE  = TW'(1);
   localparam bit            RPT_ON   = (REPEAT_EN != 0);

   logic          btn_s;
   state_t        state_reg,  state_next;
   logic [TW-1:0] timer_reg,  timer_next;
   logic          pulse_reg,  pulse_next;
   logic          db_reg,     db_next;
   logic          timer_clr;

   sync_2ff u_sync (
      .clkf (clkf),
      .rst  (rst),
      .d    (bus.btn_in),
      .q    (btn_s)
   );

   // Next-state, strobe and debounced-level decode from the synchronised button.
   always_comb begin
      state_next = state_reg;
      pulse_next = 1'b0;
      timer_clr  = 1'b0;

      unique case (state_reg)
         IDLE: begin
            if (btn_s) state_next = ARMING;
         end
         ARMING: begin
            // A press that drops before the debounce window ends is bounce.
            if (!btn_s) begin
               state_next = IDLE;
            end else if (timer_reg == DB_LAST) begin
               state_next = HELD;
               pulse_next = 1'b1;
            end
         end
         HELD: begin
            if (!btn_s) begin
               state_next = RELEASING;
            end else if (RPT_ON && (timer_reg == RD_LAST)) begin
               state_next = REPEATING;
               pulse_next = 1'b1;
            end
         end
         REPEATING: begin
            // Release takes priority over a coinciding repeat terminal count.
            if (!btn_s) begin
               state_next = RELEASING;
            end else if (timer_reg == RP_LAST) begin
               pulse_next = 1'b1;
               timer_clr  = 1'b1;
            end
         end
         RELEASING: begin
            // Going high again is release bounce: back to HELD, repeat delay
            // restarts because the state change clears the timer.
            if (btn_s) begin
               state_next = HELD;
            end else if (timer_reg == DB_LAST) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Timer restarts on any state change or repeat tick; it saturates so a
      // long hold without auto-repeat can never wrap back into a terminal count.
      if ((state_next != state_reg) || timer_clr) begin
         timer_next = '0;
      end else if (timer_reg != TMR_MAX) begin
         timer_next = timer_reg + TMR_ONE;
      end else begin
         timer_next = timer_reg;
      end

      db_next = (state_next == HELD) || (state_next == REPEATING) ||
                (state_next == RELEASING);
   end

   // State, timer and registered outputs all advance on the same edge.
   always_ff @(posedge clkf) begin
      if (rst) begin
         state_reg <= IDLE;
         timer_reg <= '0;
         pulse_reg <= 1'b0;
         db_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         timer_reg <= timer_next;
         pulse_reg <= pulse_next;
         db_reg    <= db_next;
      end
   end

   assign bus.pulse  = pulse_reg;
   assign bus.btn_db = db_reg;

endmodule

// File: tb/tb_btn_step_pulse.sv
// Directed bench for btn_step_pulse: two instances (auto-repeat off / on)
// share clock, reset and button; each scenario is a per-edge table of the
// button input with hand-derived pulse and btn_db expectations.
module tb_btn_step_pulse;

   logic clkf = 1'b0;
   logic rst  = 1'b1;
   logic btn  = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clkf = ~clkf;

   btn_step_pulse_if bus0 ();
   btn_step_pulse_if bus1 ();

   assign bus0.btn_in = btn;
   assign bus1.btn_in = btn;

   btn_step_pulse #(
      .DB_CYCLES     (4),
      .REPEAT_EN     (0),
      .REPEAT_DELAY  (10),
      .REPEAT_PERIOD (3)
   ) dut0 (
      .clkf (clkf),
      .rst  (rst),
      .bus  (bus0)
   );

   btn_step_pulse #(
      .DB_CYCLES     (4),
      .REPEAT_EN     (1),
      .REPEAT_DELAY  (10),
      .REPEAT_PERIOD (3)
   ) dut1 (
      .clkf (clkf),
      .rst  (rst),
      .bus  (bus1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] span(input int lo, input int hi);
      logic [63:0] m;
      m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   // Advance one edge and settle past it before sampling.
   task automatic tick();
      @(posedge clkf);
      #1;
   endtask

   task automatic do_reset();
      btn = 1'b0;
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      repeat (2) tick();
   endtask

   // Bit k of btn_pat is the value sampled at edge k; bit k of the expect
   // masks is the output value just after edge k.
   task automatic run_scn(input string name, input bit sel, input int n,
                          input logic [63:0] btn_pat,
                          input logic [63:0] exp_pulse,
                          input logic [63:0] exp_db);
      int   pulses;
      logic p;
      logic d;
      pulses = 0;
      for (int k = 0; k < n; k++) begin
         btn = btn_pat[k];
         tick();
         p = sel ? bus1.pulse  : bus0.pulse;
         d = sel ? bus1.btn_db : bus0.btn_db;
         chk($sformatf("%s pulse@%0d", name, k), {31'b0, p}, {31'b0, exp_pulse[k]});
         chk($sformatf("%s btn_db@%0d", name, k), {31'b0, d}, {31'b0, exp_db[k]});
         if (p) pulses++;
      end
      $display("%s: %0d edges, %0d pulses", name, n, pulses);
   endtask

   initial begin
      logic [63:0] pm;
      logic [63:0] bp;

      // Reset held with the button pressed: everything stays low.
      btn = 1'b1;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("reset pulse0 c%0d", i), {31'b0, bus0.pulse},  32'd0);
         chk($sformatf("reset db0 c%0d", i),    {31'b0, bus0.btn_db}, 32'd0);
         chk($sformatf("reset pulse1 c%0d", i), {31'b0, bus1.pulse},  32'd0);
         chk($sformatf("reset db1 c%0d", i),    {31'b0, bus1.btn_db}, 32'd0);
      end
      rst = 1'b0;
      tick();
      chk("post-reset pulse1", {31'b0, bus1.pulse},  32'd0);
      chk("post-reset db1",    {31'b0, bus1.btn_db}, 32'd0);
      $display("reset: %0d checks so far", n_checks);
      do_reset();

      // Clean press without repeat: single pulse after edge 6, db 6..25.
      pm = '0; pm[6] = 1'b1;
      run_scn("clean", 1'b0, 30, span(0, 19), pm, span(6, 25));

      // Three-cycle bounce: rejected entirely.
      run_scn("bounce", 1'b0, 12, span(0, 2), '0, '0);
      do_reset();

      // Auto-repeat: 6, then +10, then every 3 until release catches up.
      pm = '0;
      pm[6] = 1'b1; pm[16] = 1'b1; pm[19] = 1'b1; pm[22] = 1'b1;
      pm[25] = 1'b1; pm[28] = 1'b1; pm[31] = 1'b1;
      run_scn("repeat", 1'b1, 40, span(0, 29), pm, span(6, 35));
      do_reset();

      // Release bounce in HELD (low at edges 10,11): HELD re-entered at
      // edge 14, next pulse at 24, then 27, 30; final release at edge 30.
      bp = span(0, 9) | span(12, 29);
      pm = '0;
      pm[6] = 1'b1; pm[24] = 1'b1; pm[27] = 1'b1; pm[30] = 1'b1;
      run_scn("rel_bounce", 1'b1, 45, bp, pm, span(6, 35));
      do_reset();

      // Reset between repeat pulses 19 and 22, button kept pressed.
      pm = '0;
      pm[6] = 1'b1; pm[16] = 1'b1; pm[19] = 1'b1;
      run_scn("rst_mid_pre", 1'b1, 21, span(0, 20), pm, span(6, 20));
      rst = 1'b1;
      btn = 1'b1;
      tick();
      chk("rst_mid pulse", {31'b0, bus1.pulse},  32'd0);
      chk("rst_mid db",    {31'b0, bus1.btn_db}, 32'd0);
      rst = 1'b0;
      pm = '0; pm[6] = 1'b1;
      run_scn("rst_mid_post", 1'b1, 10, span(0, 9), pm, span(6, 9));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Guard against a stalled run.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
